// File: rtl/vnu_param.sv
// vnu_param: LDPC min-sum variable node unit.
// Stage 1 sums the intrinsic LLR and the incoming messages.
// Stage 2 forms the extrinsic messages, saturates them and takes the hard decision.

// One extrinsic lane. It computes E = T - X, converts E to sign-magnitude
// with clipping, and registers the result.
module vnu_lane #(
    parameter int SUM_W = 8,
    parameter int OUT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SUM_W-1:0] t_i,
    input  logic [SUM_W-1:0] x_i,
    output logic [OUT_W-1:0] y_o,
    output logic             sat_o
);
    // The compare width is wide enough for both the magnitude and the clip limit.
    localparam int CW = (SUM_W > OUT_W) ? SUM_W : OUT_W;
    localparam logic [CW-1:0] MAXM = CW'({(OUT_W-1){1'b1}});

    logic [SUM_W-1:0] e;
    logic [SUM_W-1:0] mag;
    logic [CW-1:0]    mag_ext;
    logic [CW-1:0]    mag_clip;
    logic             clip;
    logic [OUT_W-1:0] y_d;
    logic [OUT_W-1:0] y_q;
    logic             sat_q;

    // The range of T - X cannot overflow SUM_W, so the most negative value never occurs.
    assign e        = t_i - x_i;
    assign mag      = e[SUM_W-1] ? (SUM_W'(0) - e) : e;
    assign mag_ext  = CW'(mag);
    assign clip     = (mag_ext > MAXM);
    assign mag_clip = clip ? MAXM : mag_ext;
    // A negative E always has a nonzero magnitude, so a zero result keeps sign 0.
    assign y_d      = {e[SUM_W-1], mag_clip[OUT_W-2:0]};

    // Output register. It loads on every enabled cycle, independent of valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= '0;
            sat_q <= 1'b0;
        end else if (en) begin
            y_q   <= y_d;
            sat_q <= clip;
        end
    end

    assign y_o   = y_q;
    assign sat_o = sat_q;
endmodule

module vnu_param #(
    parameter int DV    = 3,
    parameter int MSG_W = 5,
    parameter int LLR_W = 5,
    parameter int OUT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic                  first_iter,
    input  logic [DV*MSG_W-1:0]   X,
    input  logic [LLR_W-1:0]      Z,
    output logic                  out_valid,
    output logic [DV*OUT_W-1:0]   Y,
    output logic                  hard_decision,
    output logic [DV-1:0]         sat
);
    localparam int IN_W  = (MSG_W > LLR_W) ? MSG_W : LLR_W;
    localparam int SUM_W = IN_W + $clog2(DV + 1) + 1;

    logic [DV-1:0][SUM_W-1:0] xm;
    logic [DV-1:0][SUM_W-1:0] xc;
    logic [SUM_W-1:0]         zm;
    logic [SUM_W-1:0]         zc;
    logic [SUM_W-1:0]         t_d;

    logic [DV-1:0][SUM_W-1:0] xs_q;
    logic [SUM_W-1:0]         t_q;
    logic                     v1_q;
    logic                     out_valid_q;
    logic                     hd_q;
    logic [DV-1:0][OUT_W-1:0] y_w;

    // Convert sign-magnitude to two's complement. Negative zero becomes 0.
    // In the first iteration the check messages do not exist yet, so they are forced to 0.
    assign zm = SUM_W'(Z[LLR_W-2:0]);
    assign zc = Z[LLR_W-1] ? (SUM_W'(0) - zm) : zm;

    for (genvar i = 0; i < DV; i++) begin : g_xc
        assign xm[i] = SUM_W'(X[i*MSG_W +: MSG_W-1]);
        assign xc[i] = first_iter ? '0
                     : (X[i*MSG_W + MSG_W-1] ? (SUM_W'(0) - xm[i]) : xm[i]);
    end

    // Posterior sum T = Z + sum(X_i).
    always_comb begin
        t_d = zc;
        for (int i = 0; i < DV; i++) t_d = t_d + xc[i];
    end

    // Stage 1 registers: posterior sum, converted messages and valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_q  <= '0;
            xs_q <= '0;
            v1_q <= 1'b0;
        end else if (en) begin
            t_q  <= t_d;
            xs_q <= xc;
            v1_q <= in_valid;
        end
    end

    // Stage 2 registers shared by all lanes: output valid and hard decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            hd_q        <= 1'b0;
        end else if (en) begin
            out_valid_q <= v1_q;
            hd_q        <= t_q[SUM_W-1];
        end
    end

    for (genvar i = 0; i < DV; i++) begin : g_lane
        vnu_lane #(.SUM_W(SUM_W), .OUT_W(OUT_W)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .t_i   (t_q),
            .x_i   (xs_q[i]),
            .y_o   (y_w[i]),
            .sat_o (sat[i])
        );
    end

    assign Y             = y_w;
    assign out_valid     = out_valid_q;
    assign hard_decision = hd_q;
endmodule

// File: tb/tb_vnu_param.sv
// Directed testbench for vnu_param with the default parameters (DV=3, 5/5/6 bit widths).
module tb_vnu_param;
    logic        clk = 1'b0;
    logic        rst, en, in_valid, first_iter;
    logic [14:0] X;
    logic [4:0]  Z;
    logic        out_valid, hard_decision;
    logic [17:0] Y;
    logic [2:0]  sat;

    int total  = 0;
    int passed = 0;

    vnu_param dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .first_iter(first_iter),
        .X(X), .Z(Z), .out_valid(out_valid), .Y(Y),
        .hard_decision(hard_decision), .sat(sat)
    );

    always #5 clk = ~clk;

    // Input vectors {X2,X1,X0}, the matching Z values, and the expected {Y2,Y1,Y0}.
    localparam logic [14:0] XA  = {5'b00101, 5'b10010, 5'b00011};
    localparam logic [4:0]  ZA  = 5'b00100;
    localparam logic [17:0] YA  = {6'b000101, 6'b001100, 6'b000111};
    localparam logic [14:0] XSP = {3{5'b01111}};
    localparam logic [4:0]  ZSP = 5'b01111;
    localparam logic [17:0] YSP = {3{6'b011111}};
    localparam logic [14:0] XSN = {3{5'b11111}};
    localparam logic [4:0]  ZSN = 5'b11111;
    localparam logic [17:0] YSN = {3{6'b111111}};
    localparam logic [14:0] XFI = {5'b00111, 5'b10001, 5'b01010};
    localparam logic [4:0]  ZFI = 5'b11001;
    localparam logic [17:0] YFI = {3{6'b101001}};
    localparam logic [14:0] XNZ = {5'b00000, 5'b10000, 5'b10010};
    localparam logic [4:0]  ZNZ = 5'b00010;
    localparam logic [17:0] YNZ = {6'b000000, 6'b000000, 6'b000010};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [17:0] y,
                           input logic hd, input logic [2:0] s);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".Y"}, 32'(Y), 32'(y));
        chk({tag, ".hd"}, 32'(hard_decision), 32'(hd));
        chk({tag, ".sat"}, 32'(sat), 32'(s));
    endtask

    task automatic drive(input logic v, input logic fi, input logic [14:0] x, input logic [4:0] z);
        in_valid = v; first_iter = fi; X = x; Z = z;
    endtask

    // Present one node for a single cycle, then let it reach the output.
    task automatic send(input logic fi, input logic [14:0] x, input logic [4:0] z);
        drive(1'b1, fi, x, z);
        tick();
        drive(1'b0, 1'b0, 15'h7fff, 5'h1f);
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        tick(); tick();
        rst = 1'b0;
        chk_out("reset", 1'b0, 18'd0, 1'b0, 3'b000);

        // Basic posterior and extrinsic values.
        send(1'b0, XA, ZA);
        chk_out("basic", 1'b1, YA, 1'b0, 3'b000);
        tick();
        chk("basic.drain", 32'(out_valid), 32'd0);

        // Saturation for positive and negative values.
        send(1'b0, XSP, ZSP);
        chk_out("satpos", 1'b1, YSP, 1'b0, 3'b111);
        send(1'b0, XSN, ZSN);
        chk_out("satneg", 1'b1, YSN, 1'b1, 3'b111);

        // First iteration: Y_i equals Z.
        send(1'b1, XFI, ZFI);
        chk_out("firstiter", 1'b1, YFI, 1'b1, 3'b000);

        // Negative zero input and zero results.
        send(1'b0, XNZ, ZNZ);
        chk_out("negzero", 1'b1, YNZ, 1'b0, 3'b000);
        tick();

        // Stall: nodes A, B, C are sent back to back, with en low for 3 cycles once B is in stage 1.
        drive(1'b1, 1'b0, XA, ZA);
        tick();
        drive(1'b1, 1'b0, XNZ, ZNZ);
        tick();
        chk_out("stall.A0", 1'b1, YA, 1'b0, 3'b000);
        en = 1'b0;
        drive(1'b1, 1'b1, XFI, ZFI);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out("stall.hold", 1'b1, YA, 1'b0, 3'b000);
        end
        en = 1'b1;
        tick();
        drive(1'b0, 1'b0, XSP, ZSP);
        chk_out("stall.B", 1'b1, YNZ, 1'b0, 3'b000);
        tick();
        chk_out("stall.C", 1'b1, YFI, 1'b1, 3'b000);
        tick();
        chk("stall.end", 32'(out_valid), 32'd0);

        // Reset with two nodes in flight (sat+ at the output, sat- in stage 1).
        drive(1'b1, 1'b0, XSP, ZSP);
        tick();
        drive(1'b1, 1'b0, XSN, ZSN);
        tick();
        chk_out("prerst", 1'b1, YSP, 1'b0, 3'b111);
        drive(1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("rst.mid", 1'b0, 18'd0, 1'b0, 3'b000);
        tick();
        chk("rst.flush1", 32'(out_valid), 32'd0);
        tick();
        chk("rst.flush2", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/vnu_param.md
# vnu_param

Parametrised variable node unit for the LDPC min-sum decoder. It accepts DV check-to-variable messages plus one intrinsic LLR per variable node, forms the posterior sum, and returns DV extrinsic variable-to-check messages and a hard decision. It is a two-stage pipeline with valid tracking, stall, saturation and a first-iteration mode. It sits between the intrinsic RAM / CNU message RAM and the CNU array.

## Interface
Parameters:
- DV, 3: variable node degree (number of message inputs/outputs), 2..8
- MSG_W, 5: width of incoming sign-magnitude message (MSB = sign)
- LLR_W, 5: width of sign-magnitude intrinsic LLR Z (MSB = sign)
- OUT_W, 6: width of outgoing sign-magnitude message (MSB = sign)
- SUM_W, max(MSG_W,LLR_W)+clog2(DV+1)+1: internal two's-complement accumulator width (derived, not overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  pipeline advance; when low every register holds
- in_valid  in  1  X/Z/first_iter carry a valid node this cycle
- first_iter  in  1  ignore X (treat all as zero); Y_i = Z
- X  in  DV*MSG_W  message i at X[i*MSG_W +: MSG_W]
- Z  in  LLR_W  intrinsic LLR
- out_valid  out  1  Y/hard_decision/sat valid
- Y  out  DV*OUT_W  extrinsic message i at Y[i*OUT_W +: OUT_W]
- hard_decision  out  1  1 when posterior sum < 0
- sat  out  DV  sat[i] = 1 when Y_i magnitude was clipped

## Operation
- Stage 1 (when en): convert each X_i and Z from sign-magnitude to SUM_W two's complement (-0 maps to 0); if first_iter, X_i forced to 0. Register T = Z + sum(X_i), each converted X_i, and v1 <= in_valid.
- Stage 2 (when en): E_i = T - X_i (SUM_W, no overflow by construction); hard_decision <= T[SUM_W-1]; convert E_i to sign-magnitude; if |E_i| > 2^(OUT_W-1)-1 clip magnitude to 2^(OUT_W-1)-1 and set sat[i]; zero result always has sign 0. out_valid <= v1.
- Y, hard_decision, sat register only when en; they update regardless of v1 (data qualified solely by out_valid).
- DV=2, MSG_W, LLR_W, OUT_W independent; OUT_W smaller than MSG_W is legal (saturation covers it).

## Timing
- Latency: 2 enabled cycles from in_valid sample to out_valid; throughput one node per enabled cycle.
- en low: v1, out_valid, all data registers hold; no bubble inserted, no data lost.
- Reset (rst high at a clock edge, overrides en): v1, out_valid, hard_decision, Y, sat, T and stage-1 registers all cleared to 0. Reset mid-pipeline discards in-flight nodes; first out_valid after release no earlier than 2 enabled cycles after first in_valid.
- in_valid low: pipeline still advances; out_valid deasserts 2 enabled cycles later.

## Test plan
- DV=3 defaults, first_iter=0, Z=+4, X={+3,-2,+5} (5'b00011,5'b10010,5'b00101), en=1 -> 2 cycles later out_valid=1, T=10, Y0=+7 (6'b000111), Y1=+12 (6'b001100), Y2=+5 (6'b000101), hard_decision=0, sat=0.
- Saturation: Z=+15, X all +15 -> T=60, each E=45 -> Y_i=6'b011111, sat=3'b111; repeat all -15 -> Y_i=6'b111111, hard_decision=1, sat=3'b111.
- first_iter=1, Z=-9 (5'b11001), X arbitrary nonzero -> Y_i=6'b101001 for all i, hard_decision=1, sat=0.
- Negative zero and zero result: Z=+2, X={-2,-0,+0} -> T=0, Y0=+2, Y1=Y2=6'b000000 (sign 0), hard_decision=0.
- Stall: stream nodes A,B,C back-to-back, hold en=0 for 3 cycles after B enters -> outputs frozen, A,B,C emerge in order with no duplicates or drops.
- Reset mid-operation: rst high for 1 cycle with two nodes in flight -> next cycle out_valid=0, Y=0, hard_decision=0, sat=0; in-flight nodes never appear.
